hqm_list_sel_mem_rf_pg_gen: RTL and testbench
=============================================

HQM_LIST_SEL_MEM_RF_PG_GEN -- requirements
Module: hqm_list_sel_mem_rf_pg_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..1024, not required to be a power of 2).
REQ-002 SHALL have parameter WIDTH, default 73, data bits per entry (1..256).
REQ-003 SHALL have parameter WAKE_CYC, default 8, wake delay in clk cycles (1..255).
REQ-004 SHALL derive AW = max(1, clog2(DEPTH)) as the address width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port list:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- we  in  1  write request
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- re  in  1  read request
- raddr  in  AW  read address
- rdata  out  WIDTH  registered read data
- rvalid  out  1  rdata valid pulse
- mem_rdy  out  1  array powered and accessible
- drop_err  out  1  pulse: request ignored because mem_rdy=0
- pwr_down_req  in  1  level: request power-down
- isol_en  out  1  output isolation active
- pwr_enable_b  out  1  array power switch off (active-low enable)
- par_inj  in  1  corrupt stored parity of current write
- par_err  out  1  pulse: parity mismatch on read

Function
REQ-007 Read latency SHALL be 1: re=1 and mem_rdy=1 in cycle N gives rvalid=1 and rdata in N+1; rdata holds its value until the next accepted read.
REQ-008 Same-cycle read and write to one address SHALL return the old data (read-before-write).
REQ-009 Address >= DEPTH: write SHALL be discarded; read SHALL return all-zeros with rvalid=1.
REQ-010 re or we with mem_rdy=0 SHALL be ignored, with drop_err=1 in the following cycle.
REQ-011 FSM states SHALL be ON, ISO, OFF and WAKE.
REQ-012 ON: mem_rdy=1, isol_en=0, pwr_enable_b=0; go to ISO when pwr_down_req=1 and re=0 and we=0; otherwise stay in ON.
REQ-013 ISO: mem_rdy=0, isol_en=1, pwr_enable_b=0; go to OFF unconditionally after 1 cycle.
REQ-014 OFF: isol_en=1, pwr_enable_b=1; all entries and stored parity SHALL be cleared to 0 on entry; go to WAKE when pwr_down_req=0.
REQ-015 WAKE: isol_en=1, pwr_enable_b=0; load counter with WAKE_CYC-1 on entry and decrement each cycle; go to ON in the cycle after the counter reads 0.
REQ-016 pwr_down_req dropping during ISO SHALL NOT abort; the FSM completes ISO->OFF->WAKE.
REQ-017 pwr_down_req rising during WAKE SHALL be ignored until ON is reached.
REQ-018 rvalid for a read accepted in the last ON cycle SHALL still be delivered in the ISO cycle.

Reset
REQ-019 While rst=1, state SHALL be ON, wake counter 0 and all entries 0.
REQ-020 While rst=1, outputs SHALL be: rdata=0, rvalid=0, drop_err=0, par_err=0, mem_rdy=1, isol_en=0, pwr_enable_b=0.
REQ-021 Reset asserted mid-operation (any state) SHALL take effect immediately and asynchronously; no in-flight rvalid is delivered after rst releases.

Configuration
REQ-022 With macro HQM_LIST_SEL_MEM_RF_PG_PARITY_EN defined: one even-parity bit SHALL be stored per entry, computed over wdata and inverted when par_inj=1.
REQ-023 With the macro defined: each accepted in-range read SHALL recompute parity, and par_err SHALL equal the mismatch, aligned with rvalid.
REQ-024 Without the macro: no parity storage; par_err SHALL be tied to 0 and par_inj SHALL be ignored.

Verification
REQ-025 Write 0x1_2345_6789_ABCD_EF01 to addr 2, read addr 2 next cycle -> rvalid=1 with that data one cycle after re.
REQ-026 Addr 1 holds 0xA5; same-cycle we addr 1 = 0x5A and re addr 1 -> rdata=0xA5; a following read returns 0x5A.
REQ-027 pwr_down_req=1 with WAKE_CYC=8: ISO 1 cycle, OFF while req=1, then 8 WAKE cycles -> ON; a read in WAKE gives drop_err=1; a subsequent read of any entry returns 0.
REQ-028 DEPTH=3: write addr 3 then read addr 3 -> rdata=0, rvalid=1; entries 0-2 are unchanged.
REQ-029 Macro defined: write addr 0 with par_inj=1, read addr 0 -> par_err=1 with rvalid; rewrite with par_inj=0 and read -> par_err=0.
REQ-030 rst pulsed during WAKE -> state ON, mem_rdy=1, isol_en=0 immediately; all entries read as 0.

Source files
------------

// File: rtl/hqm_list_sel_mem_rf_pg_gen.sv
// Power-gated register-file array: 1-cycle read, read-before-write, ON/ISO/OFF/WAKE sequencing.
// Optional per-entry even parity enabled by defining HQM_LIST_SEL_MEM_RF_PG_PARITY_EN.
module hqm_list_sel_mem_rf_pg_gen #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 73,
  parameter int unsigned WAKE_CYC = 8,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             mem_rdy,
  output logic             drop_err,
  input  logic             pwr_down_req,
  output logic             isol_en,
  output logic             pwr_enable_b,
  input  logic             par_inj,
  output logic             par_err
);

  typedef enum logic [1:0] {ST_ON, ST_ISO, ST_OFF, ST_WAKE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             drop_err_q, drop_err_d;
  logic             par_err_q, par_err_d;
  logic             mem_rdy_q, mem_rdy_d;
  logic             isol_en_q, isol_en_d;
  logic             pwr_enable_b_q, pwr_enable_b_d;

  logic             rd_acc, wr_acc, rd_in, wr_in;
  logic [WIDTH-1:0] rd_word;

`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
  logic             rd_par;
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    drop_err_d = 1'b0;
    par_err_d  = 1'b0;
    rd_word    = '0;
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
    par_d      = par_q;
    rd_par     = 1'b0;
`endif

    rd_acc = re && (state_q == ST_ON);
    wr_acc = we && (state_q == ST_ON);
    rd_in  = 32'(raddr) < DEPTH;
    wr_in  = 32'(waddr) < DEPTH;

    // Mux by compare so a non-power-of-2 DEPTH never indexes past the array.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        rd_word = mem_q[i];
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
        rd_par  = par_q[i];
`endif
      end
    end

    drop_err_d = (re || we) && (state_q != ST_ON);
    rvalid_d   = rd_acc;
    if (rd_acc) begin
      rdata_d = rd_in ? rd_word : '0;
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
      par_err_d = rd_in && ((^rd_word) != rd_par);
`endif
    end

    if (wr_acc && wr_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (waddr == AW'(i)) begin
          mem_d[i] = wdata;
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
          par_d[i] = (^wdata) ^ par_inj;
`endif
        end
      end
    end

    case (state_q)
      ST_ON: begin
        if (pwr_down_req && !re && !we) state_d = ST_ISO;
      end
      ST_ISO: begin
        state_d = ST_OFF;
        // Array contents are lost as power drops; clear them on the way into OFF.
        for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = '0;
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
        par_d = '0;
`endif
      end
      ST_OFF: begin
        if (!pwr_down_req) begin
          state_d = ST_WAKE;
          cnt_d   = 8'(WAKE_CYC - 1);
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) state_d = ST_ON;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_ON;
    endcase

    mem_rdy_d      = (state_d == ST_ON);
    isol_en_d      = (state_d != ST_ON);
    pwr_enable_b_d = (state_d == ST_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ON;
      cnt_q          <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
      drop_err_q     <= 1'b0;
      par_err_q      <= 1'b0;
      mem_rdy_q      <= 1'b1;
      isol_en_q      <= 1'b0;
      pwr_enable_b_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
      par_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= rvalid_d;
      drop_err_q     <= drop_err_d;
      par_err_q      <= par_err_d;
      mem_rdy_q      <= mem_rdy_d;
      isol_en_q      <= isol_en_d;
      pwr_enable_b_q <= pwr_enable_b_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
      par_q          <= par_d;
`endif
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign drop_err     = drop_err_q;
  assign mem_rdy      = mem_rdy_q;
  assign isol_en      = isol_en_q;
  assign pwr_enable_b = pwr_enable_b_q;
  assign par_err      = par_err_q;

endmodule

// File: tb/tb_hqm_list_sel_mem_rf_pg_gen.sv
// Bench for hqm_list_sel_mem_rf_pg_gen (DEPTH=3): directed vector table, power sequencing, random traffic vs model.
module tb_hqm_list_sel_mem_rf_pg_gen;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned WIDTH = 73;
  localparam int unsigned AW    = 2;
`ifdef HQM_LIST_SEL_MEM_RF_PG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             we, re, par_inj, pwr_down_req;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid, mem_rdy, drop_err, isol_en, pwr_enable_b, par_err;

  int errors = 0;
  int checks = 0;

  hqm_list_sel_mem_rf_pg_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WAKE_CYC(8)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .mem_rdy(mem_rdy), .drop_err(drop_err),
    .pwr_down_req(pwr_down_req), .isol_en(isol_en), .pwr_enable_b(pwr_enable_b),
    .par_inj(par_inj), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             inj;
    logic             re;
    logic [AW-1:0]    raddr;
    logic             exp_rvalid;
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_inj_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; par_inj = 1'b0;
  endtask

  task automatic chk_pwr(input string nm, input logic rdy, input logic iso, input logic pb);
    chk1({nm, "_mem_rdy"}, mem_rdy, rdy);
    chk1({nm, "_isol_en"}, isol_en, iso);
    chk1({nm, "_pwr_enable_b"}, pwr_enable_b, pb);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    idle(); re = 1'b1; raddr = a;
    step();
    idle();
  endtask

  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_inj [DEPTH];
  logic [WIDTH-1:0] m_rdata;
  logic             m_in;
  int               wake_cnt;

  initial begin
    d1 = 73'h1_2345_6789_ABCD_EF01;
    vecs[0]  = '{1'b1, 2'd2, d1,      1'b0, 1'b0, 2'd0, 1'b0, '0,      1'b0};
    vecs[1]  = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd2, 1'b1, d1,      1'b0};
    vecs[2]  = '{1'b1, 2'd1, 73'hA5,  1'b0, 1'b0, 2'd0, 1'b0, d1,      1'b0};
    vecs[3]  = '{1'b1, 2'd1, 73'h5A,  1'b0, 1'b1, 2'd1, 1'b1, 73'hA5,  1'b0};
    vecs[4]  = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd1, 1'b1, 73'h5A,  1'b0};
    vecs[5]  = '{1'b1, 2'd3, '1,      1'b0, 1'b0, 2'd0, 1'b0, 73'h5A,  1'b0};
    vecs[6]  = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd3, 1'b1, '0,      1'b0};
    vecs[7]  = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd2, 1'b1, d1,      1'b0};
    vecs[8]  = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd0, 1'b1, '0,      1'b0};
    vecs[9]  = '{1'b1, 2'd0, 73'h3,   1'b1, 1'b0, 2'd0, 1'b0, '0,      1'b0};
    vecs[10] = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd0, 1'b1, 73'h3,   1'b1};
    vecs[11] = '{1'b1, 2'd0, 73'h3,   1'b0, 1'b0, 2'd0, 1'b0, 73'h3,   1'b0};
    vecs[12] = '{1'b0, 2'd0, '0,      1'b0, 1'b1, 2'd0, 1'b1, 73'h3,   1'b0};

    rst = 1'b1; pwr_down_req = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    idle();
    #3;
    chkw("rst_rdata", rdata, '0);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_drop_err", drop_err, 1'b0);
    chk1("rst_par_err", par_err, 1'b0);
    chk_pwr("rst", 1'b1, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; par_inj = vecs[i].inj;
      re = vecs[i].re; raddr = vecs[i].raddr;
      step();
      chk1($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].exp_rvalid);
      chkw($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk1($sformatf("vec%0d_par_err", i), par_err, vecs[i].exp_inj_err & PAR_EN);
      chk1($sformatf("vec%0d_drop_err", i), drop_err, 1'b0);
      chk1($sformatf("vec%0d_mem_rdy", i), mem_rdy, 1'b1);
    end
    idle();

    // Power-down request held off by a read in the same cycle
    pwr_down_req = 1'b1; re = 1'b1; raddr = 2'd1;
    step();
    chk1("pd_busy_rvalid", rvalid, 1'b1);
    chkw("pd_busy_rdata", rdata, 73'h5A);
    chk_pwr("pd_busy", 1'b1, 1'b0, 1'b0);
    idle();
    step();
    chk_pwr("iso", 1'b0, 1'b1, 1'b0);
    chk1("iso_rvalid", rvalid, 1'b0);
    pwr_down_req = 1'b0;
    step();
    chk_pwr("off_after_iso_drop", 1'b0, 1'b1, 1'b1);
    pwr_down_req = 1'b1;
    we = 1'b1; waddr = 2'd0; wdata = 73'h77;
    step();
    chk1("off_write_drop_err", drop_err, 1'b1);
    chk_pwr("off_hold", 1'b0, 1'b1, 1'b1);
    idle();
    step();
    chk1("off_drop_err_clear", drop_err, 1'b0);
    chk_pwr("off_hold2", 1'b0, 1'b1, 1'b1);
    pwr_down_req = 1'b0;
    step();
    chk_pwr("wake_entry", 1'b0, 1'b1, 1'b0);
    wake_cnt = 1;
    re = 1'b1; raddr = 2'd1;
    step();
    chk1("wake_read_drop_err", drop_err, 1'b1);
    chk1("wake_read_rvalid", rvalid, 1'b0);
    if (isol_en && !pwr_enable_b) wake_cnt++;
    for (int k = 0; k < 40; k++) begin
      idle();
      pwr_down_req = (wake_cnt >= 3 && wake_cnt <= 5);
      step();
      if (isol_en && !pwr_enable_b) wake_cnt++;
      else break;
    end
    pwr_down_req = 1'b0;
    chk1("wake_len_is_8", wake_cnt == 8, 1'b1);
    if (wake_cnt != 8) $display("  wake cycles counted: %0d", wake_cnt);
    chk_pwr("back_on", 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) begin
      rd(AW'(a));
      chk1($sformatf("post_off_rvalid%0d", a), rvalid, 1'b1);
      chkw($sformatf("post_off_rdata%0d", a), rdata, '0);
    end

    // Reset asserted mid-WAKE takes effect without a clock edge
    we = 1'b1; waddr = 2'd2; wdata = 73'h1234;
    step();
    idle();
    pwr_down_req = 1'b1;
    step();
    pwr_down_req = 1'b0;
    step(); step(); step(); step();
    chk_pwr("wake2", 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_pwr("rst_in_wake", 1'b1, 1'b0, 1'b0);
    chk1("rst_in_wake_rvalid", rvalid, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_pwr("after_rst", 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 3; a++) m_mem[a] = '0;
    for (int a = 0; a < 3; a++) m_inj[a] = 1'b0;
    m_rdata = '0;
    for (int a = 0; a < 3; a++) begin
      rd(AW'(a));
      chkw($sformatf("rst_wake_rdata%0d", a), rdata, '0);
    end

    // Random traffic in ON against a simple array model
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      waddr = AW'($urandom_range(0, 3));
      raddr = AW'($urandom_range(0, 3));
      wdata = 73'({$urandom(), $urandom(), $urandom()});
      par_inj = ($urandom_range(0, 7) == 0);
      m_in = (raddr < 2'd3);
      if (re) m_rdata = m_in ? m_mem[raddr] : '0;
      step();
      chk1("rnd_rvalid", rvalid, re);
      chkw("rnd_rdata", rdata, m_rdata);
      chk1("rnd_par_err", par_err, re && m_in && m_inj[raddr] && PAR_EN);
      chk1("rnd_drop_err", drop_err, 1'b0);
      if (we && waddr < 2'd3) begin
        m_mem[waddr] = wdata;
        m_inj[waddr] = par_inj;
      end
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
